// File: rtl/multiword_add_seq_if.sv
// Beat stream bundle for multiword_add_seq: operand beats in, sum beats out.
// The design side uses the slave modport; the producer/consumer uses master.
interface multiword_add_seq_if #(
    parameter int N     = 32,
    parameter int CNT_W = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [N-1:0]     in_a;
    logic [N-1:0]     in_b;
    logic             in_cin;
    logic             in_last;
    logic             out_valid;
    logic             out_ready;
    logic [N-1:0]     out_sum;
    logic             out_cout;
    logic             out_last;
    logic [CNT_W-1:0] out_idx;
    logic             out_ovf;

    modport slave (
        input  in_valid,
        input  in_a,
        input  in_b,
        input  in_cin,
        input  in_last,
        input  out_ready,
        output in_ready,
        output out_valid,
        output out_sum,
        output out_cout,
        output out_last,
        output out_idx,
        output out_ovf
    );

    modport master (
        output in_valid,
        output in_a,
        output in_b,
        output in_cin,
        output in_last,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  out_sum,
        input  out_cout,
        input  out_last,
        input  out_idx,
        input  out_ovf
    );
endinterface

// File: rtl/multiword_add_seq.sv
// Multi-beat adder sequencer with a 2-entry registered output FIFO.
// Define MULTIWORD_ADD_OVF_EN to generate packet signed-overflow on out_ovf.
module multiword_add_seq #(
    parameter int N     = 32,
    parameter int CNT_W = 8
) (
    input logic          clk,
    input logic          rst_n,
    multiword_add_seq_if.slave bus
);
    typedef enum logic {FIRST, MID} state_t;

    typedef struct packed {
        logic [N-1:0]     sum;
        logic             cout;
        logic             last;
        logic [CNT_W-1:0] idx;
    } ent_t;

    state_t           state_q, state_d;
    logic             carry_q, carry_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             c;
    logic [N:0]       res;
    ent_t             ent;
    logic             acc;
    logic             pop;
    logic             in_rdy;

    ent_t       mem0, mem1, head;
    logic       rd_q, wr_q;
    logic [1:0] fcnt_q;

    // in_ready depends only on the registered occupancy
    assign in_rdy = (fcnt_q != 2'd2);
    assign acc    = bus.in_valid && in_rdy;
    assign pop    = (fcnt_q != 2'd0) && bus.out_ready;

    always_comb begin
        state_d = state_q;
        carry_d = carry_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            FIRST:   c = bus.in_cin;
            MID:     c = carry_q;
            default: c = 1'b0;
        endcase
        res = {1'b0, bus.in_a} + {1'b0, bus.in_b}
            + {{N{1'b0}}, c};
        ent.sum  = res[N-1:0];
        ent.cout = res[N];
        ent.last = bus.in_last;
        ent.idx  = cnt_q;
        if (acc) begin
            carry_d = res[N];
            if (bus.in_last) begin
                state_d = FIRST;
                cnt_d   = '0;
            end else begin
                state_d = MID;
                cnt_d   = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= FIRST;
            carry_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            carry_q <= carry_d;
            cnt_q   <= cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            mem0   <= '0;
            mem1   <= '0;
            rd_q   <= 1'b0;
            wr_q   <= 1'b0;
            fcnt_q <= 2'd0;
        end else begin
            if (acc) begin
                if (wr_q) mem1 <= ent;
                else      mem0 <= ent;
                wr_q <= ~wr_q;
            end
            if (pop) rd_q <= ~rd_q;
            fcnt_q <= fcnt_q + {1'b0, acc} - {1'b0, pop};
        end
    end

    assign head          = rd_q ? mem1 : mem0;
    assign bus.in_ready  = in_rdy;
    assign bus.out_valid = (fcnt_q != 2'd0);
    assign bus.out_sum   = head.sum;
    assign bus.out_cout  = head.cout;
    assign bus.out_last  = head.last;
    assign bus.out_idx   = head.idx;

`ifdef MULTIWORD_ADD_OVF_EN
    logic ovf_in, ovf0, ovf1;

    assign ovf_in = bus.in_last
                 && (bus.in_a[N-1] == bus.in_b[N-1])
                 && (res[N-1] != bus.in_a[N-1]);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ovf0 <= 1'b0;
            ovf1 <= 1'b0;
        end else if (acc) begin
            if (wr_q) ovf1 <= ovf_in;
            else      ovf0 <= ovf_in;
        end
    end

    assign bus.out_ovf = rd_q ? ovf1 : ovf0;
`else
    assign bus.out_ovf = 1'b0;
`endif
endmodule
